// File: rtl/display_link_pkg.sv
// Shared constants and types for the calculator display link.
// Both the serializer and this receiver import it, so frame size and
// default timeout agree on both ends of the link.
package display_link_pkg;

    localparam int NBITS                  = 16;
    localparam int DIGITS                 = 4;
    localparam int DIGIT_W                = 4;
    localparam int BCD_MAX                = 9;
    localparam int TIMEOUT_CYCLES_DEFAULT = 262143;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // True when every 4-bit digit of the frame is a legal BCD value.
    function automatic logic bcd_is_valid(input logic [NBITS-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (v[d*DIGIT_W +: DIGIT_W] > DIGIT_W'(BCD_MAX)) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/display_rx_if.sv
// Display link bundle: the three serial link lines plus the receiver's
// result outputs. The master drives the link and observes the results;
// the slave is the receiver.
interface display_rx_if;
    import display_link_pkg::*;

    logic             ser_clk_in;
    logic             data_en_in;
    logic             data_in;
    logic [NBITS-1:0] bcd_out;
    logic             frame_valid;
    logic             frame_err;
    logic             busy;

    modport master (
        output ser_clk_in, data_en_in, data_in,
        input  bcd_out, frame_valid, frame_err, busy
    );

    modport slave (
        input  ser_clk_in, data_en_in, data_in,
        output bcd_out, frame_valid, frame_err, busy
    );

endinterface

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for one asynchronous link line, followed by one
// extra register so rising and falling edges can be detected on the
// synchronised level.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Shift the raw line through the synchroniser chain and keep the previous level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/display_rx.sv
// Display link receiver: deserialises one 16-bit frame of 4 BCD digits
// (MSB first) and presents it with a one-cycle frame_valid strobe, or
// flags a rejected frame with a one-cycle frame_err strobe.
// Optional stall timeout is enabled by defining DISPLAY_RX_TIMEOUT_EN.
module display_rx
    import display_link_pkg::*;
#(
    parameter int SYNC_STAGES = 2
`ifdef DISPLAY_RX_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
`endif
) (
    input  logic         clk,
    input  logic         rst,
    display_rx_if.slave  link
);

    localparam int CW = $clog2(NBITS + 1);

    logic w_ser_s, w_ser_rise, w_ser_fall;
    logic w_en_s, w_en_rise, w_en_fall;
    logic w_dat_s, w_dat_rise, w_dat_fall;
    logic [3:0] w_unused_edges;

    state_t           r_state, w_state_next;
    logic [NBITS-1:0] r_shift, w_shift_next;
    logic [NBITS-1:0] r_bcd, w_bcd_next;
    logic [CW-1:0]    r_count, w_count_next;
    logic             r_valid, w_valid_next;
    logic             r_err, w_err_next;

`ifdef DISPLAY_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tmo, w_tmo_next;
`endif

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ser (
        .clk(clk), .rst(rst), .i_async(link.ser_clk_in),
        .o_level(w_ser_s), .o_rise(w_ser_rise), .o_fall(w_ser_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_en (
        .clk(clk), .rst(rst), .i_async(link.data_en_in),
        .o_level(w_en_s), .o_rise(w_en_rise), .o_fall(w_en_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dat (
        .clk(clk), .rst(rst), .i_async(link.data_in),
        .o_level(w_dat_s), .o_rise(w_dat_rise), .o_fall(w_dat_fall)
    );

    assign w_unused_edges = {w_ser_s, w_ser_fall, w_dat_rise, w_dat_fall};

    // Register the FSM state, frame shifter, bit count, result and strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_bcd   <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
`ifdef DISPLAY_RX_TIMEOUT_EN
            r_tmo   <= '0;
`endif
        end else begin
            r_state <= w_state_next;
            r_shift <= w_shift_next;
            r_bcd   <= w_bcd_next;
            r_count <= w_count_next;
            r_valid <= w_valid_next;
            r_err   <= w_err_next;
`ifdef DISPLAY_RX_TIMEOUT_EN
            r_tmo   <= w_tmo_next;
`endif
        end
    end

    // Next-state logic; en_fall is checked first so a bit edge coinciding with it is dropped.
    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_bcd_next   = r_bcd;
        w_count_next = r_count;
        w_valid_next = 1'b0;
        w_err_next   = 1'b0;
`ifdef DISPLAY_RX_TIMEOUT_EN
        w_tmo_next   = r_tmo;
`endif
        case (r_state)
            IDLE: begin
                if (w_en_rise) begin
                    w_state_next = SHIFT;
                    w_shift_next = '0;
                    w_count_next = '0;
`ifdef DISPLAY_RX_TIMEOUT_EN
                    w_tmo_next   = TW'(TIMEOUT_CYCLES);
`endif
                end
            end
            SHIFT: begin
                if (w_en_fall) begin
                    w_state_next = IDLE;
                    if (r_count == CW'(NBITS) && bcd_is_valid(r_shift)) begin
                        w_bcd_next   = r_shift;
                        w_valid_next = 1'b1;
                    end else begin
                        w_err_next   = 1'b1;
                    end
                end else if (w_ser_rise && w_en_s) begin
`ifdef DISPLAY_RX_TIMEOUT_EN
                    w_tmo_next = TW'(TIMEOUT_CYCLES);
`endif
                    if (r_count == CW'(NBITS)) begin
                        w_err_next   = 1'b1;
                        w_state_next = DRAIN;
                    end else begin
                        w_shift_next = {r_shift[NBITS-2:0], w_dat_s};
                        w_count_next = r_count + 1'b1;
                    end
                end
`ifdef DISPLAY_RX_TIMEOUT_EN
                else if (r_tmo == '0) begin
                    w_err_next   = 1'b1;
                    w_state_next = DRAIN;
                end else begin
                    w_tmo_next = r_tmo - 1'b1;
                end
`endif
            end
            DRAIN: begin
                if (!w_en_s) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign link.bcd_out     = r_bcd;
    assign link.frame_valid = r_valid;
    assign link.frame_err   = r_err;
    assign link.busy        = (r_state == SHIFT);

endmodule

// File: tb/tb_display_rx.sv
// Testbench for display_rx: drives directed display-link frames and checks
// every pulse and bcd_out value against a frame-level expectation queue.
// Timeout behaviour depends on DISPLAY_RX_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_display_rx;

    localparam int SYNC = 2;
    localparam int TMO  = 100;

    typedef struct {
        bit          isValid;
        logic [15:0] value;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   nChecks = 0;
    int   nFails = 0;
    int   pulseCycle = 0;
    int   enDropCycle = 0;
    logic [15:0] modelBcd = 16'h0000;
    exp_t expQ[$];

    display_rx_if link();

    display_rx #(
        .SYNC_STAGES(SYNC)
`ifdef DISPLAY_RX_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(TMO)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .link(link)
    );

    // Free-running core clock and a cycle counter used for latency checks.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Frame-level reference: a frame is good only with exactly 16 bits and all digits <= 9.
    function automatic bit bcdOk(input logic [15:0] v);
        for (int d = 0; d < 4; d++) begin
            if (((v >> (4 * d)) & 16'h000F) > 16'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic expectFrame(input logic [15:0] v, input int nbits);
        exp_t e;
        e.isValid = (nbits == 16) && bcdOk(v);
        e.value   = v;
        expQ.push_back(e);
    endtask

    // Compare process: every cycle out of reset, pulses must match the queue and bcd_out the model.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("pulse_exclusive", {31'b0, link.frame_valid & link.frame_err}, 32'd0);
            if (link.frame_valid || link.frame_err) begin
                pulseCycle = cyc;
                if (expQ.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("[TB] FAIL unexpected_pulse: got valid=%0b err=%0b, expected no pulse (cycle %0d)",
                             link.frame_valid, link.frame_err, cyc);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput("pulse_kind_valid", {31'b0, link.frame_valid}, {31'b0, e.isValid});
                    if (e.isValid) modelBcd = e.value;
                end
            end
            checkOutput("bcd_out", {16'b0, link.bcd_out}, {16'b0, modelBcd});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sendBit(input logic b);
        link.data_in = b;
        tick(4);
        link.ser_clk_in = 1'b1;
        tick(4);
        link.ser_clk_in = 1'b0;
    endtask

    task automatic applyStimulus(input logic [15:0] v, input int nbits);
        logic b;
        link.data_en_in = 1'b1;
        tick(4);
        for (int i = 0; i < nbits; i++) begin
            if (i < 16) b = v[15 - i];
            else        b = 1'b0;
            sendBit(b);
        end
        tick(4);
        checkOutput("busy_before_en_drop", {31'b0, link.busy}, {31'b0, (nbits <= 16)});
        link.data_en_in = 1'b0;
        link.data_in    = 1'b0;
        enDropCycle     = cyc;
    endtask

    task automatic waitDrained(input string name);
        for (int k = 0; k < 20; k++) begin
            if (expQ.size() == 0) break;
            tick(1);
        end
        checkOutput(name, expQ.size(), 32'd0);
        tick(2);
    endtask

    // Watchdog so the run always ends even if the DUT stops responding.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        link.ser_clk_in = 1'b0;
        link.data_en_in = 1'b0;
        link.data_in    = 1'b0;
        rst = 1'b1;
        tick(3);
        checkOutput("reset_bcd", {16'b0, link.bcd_out}, 32'h0);
        checkOutput("reset_valid", {31'b0, link.frame_valid}, 32'd0);
        checkOutput("reset_err", {31'b0, link.frame_err}, 32'd0);
        checkOutput("reset_busy", {31'b0, link.busy}, 32'd0);
        rst = 1'b0;
        tick(3);

        $display("[TB] good frame 0x1234");
        expectFrame(16'h1234, 16);
        applyStimulus(16'h1234, 16);
        waitDrained("good_1234_pulse");
        checkOutput("valid_latency", pulseCycle - enDropCycle, 32'd3);
        checkOutput("bcd_1234", {16'b0, link.bcd_out}, 32'h1234);
        checkOutput("busy_after_1234", {31'b0, link.busy}, 32'd0);

        $display("[TB] short frame of 12 bits");
        expectFrame(16'hABCD, 12);
        applyStimulus(16'hABCD, 12);
        waitDrained("short_err_pulse");
        checkOutput("bcd_after_short", {16'b0, link.bcd_out}, 32'h1234);

        $display("[TB] overrun with 17 edges, then 0x0987");
        expectFrame(16'hFFFF, 17);
        applyStimulus(16'hFFFF, 17);
        waitDrained("overrun_err_pulse");
        checkOutput("bcd_after_overrun", {16'b0, link.bcd_out}, 32'h1234);
        expectFrame(16'h0987, 16);
        applyStimulus(16'h0987, 16);
        waitDrained("good_0987_pulse");
        checkOutput("bcd_0987", {16'b0, link.bcd_out}, 32'h0987);

        $display("[TB] illegal digit frame 0x12A4");
        expectFrame(16'h12A4, 16);
        applyStimulus(16'h12A4, 16);
        waitDrained("bad_digit_err_pulse");
        checkOutput("bcd_after_bad_digit", {16'b0, link.bcd_out}, 32'h0987);

        $display("[TB] reset after 8 bits, then 0x5555");
        link.data_en_in = 1'b1;
        tick(4);
        for (int i = 0; i < 8; i++) sendBit(i[0]);
        tick(4);
        checkOutput("busy_mid_frame", {31'b0, link.busy}, 32'd1);
        modelBcd = 16'h0000;
        rst = 1'b1;
        link.data_en_in = 1'b0;
        link.data_in    = 1'b0;
        tick(3);
        checkOutput("busy_in_reset", {31'b0, link.busy}, 32'd0);
        checkOutput("bcd_in_reset", {16'b0, link.bcd_out}, 32'h0);
        rst = 1'b0;
        tick(5);
        checkOutput("no_pulse_after_abort", expQ.size(), 32'd0);
        expectFrame(16'h5555, 16);
        applyStimulus(16'h5555, 16);
        waitDrained("good_5555_pulse");
        checkOutput("bcd_5555", {16'b0, link.bcd_out}, 32'h5555);

        $display("[TB] ser_clk stall after 3 bits");
        link.data_en_in = 1'b1;
        tick(4);
`ifdef DISPLAY_RX_TIMEOUT_EN
        expectFrame(16'h0000, 3);
`endif
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b1);
        tick(150);
`ifdef DISPLAY_RX_TIMEOUT_EN
        checkOutput("timeout_err_pulse", expQ.size(), 32'd0);
        checkOutput("busy_after_timeout", {31'b0, link.busy}, 32'd0);
        link.data_en_in = 1'b0;
        tick(10);
        checkOutput("no_pulse_after_drain", expQ.size(), 32'd0);
`else
        checkOutput("busy_during_stall", {31'b0, link.busy}, 32'd1);
        checkOutput("no_pulse_during_stall", expQ.size(), 32'd0);
        expectFrame(16'h0000, 3);
        link.data_en_in = 1'b0;
        waitDrained("stall_end_err_pulse");
`endif
        checkOutput("bcd_after_stall", {16'b0, link.bcd_out}, 32'h5555);

        tick(5);
        checkOutput("queue_empty_at_end", expQ.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
